cache_ctrl: RTL and testbench

Sequencing controller for the direct-mapped data cache, between the core's memory port (MWR/MOE/Adr/MWD/CRD) and the backing memory. Holds the tag/valid/data store and runs hit detection and read-miss refill. Writes are write-through, no-write-allocate. Each core access is one request/done transaction, so the core stalls on misses and writes.

---
 rtl/cache_pkg.sv | 31 +++
 rtl/cache_line_store.sv | 42 ++++
 rtl/cache_ctrl.sv | 129 ++++++++++++
 tb/tb_cache_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and address helpers for the direct-mapped data cache.
// Used by the controller FSM and the line store.
package cache_pkg;

  localparam int ADDR_W   = 32;
  localparam int WORD_W   = 32;
  localparam int OFFSET_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] tag;
    logic [ADDR_W-1:0] idx;
  } addr_split_t;

  function automatic addr_split_t split_addr(
    input logic [ADDR_W-1:0] a,
    input int                idx_w
  );
    addr_split_t s;
    s.idx = (a >> OFFSET_W) & ((ADDR_W'(1) << idx_w) - ADDR_W'(1));
    s.tag = a >> (OFFSET_W + idx_w);
    return s;
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data arrays of the cache with one write port.
// Hit and read data are combinational on the current index.
module cache_line_store
  import cache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx,
  input  logic [TAG_W-1:0]  tag,
  input  logic              we,
  input  logic [WORD_W-1:0] wdata,
  output logic              hit,
  output logic [WORD_W-1:0] rdata
);

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags [LINES];
  logic [WORD_W-1:0] data [LINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (we) begin
      valid[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst) begin
      tags[idx] <= tag;
      data[idx] <= wdata;
    end
  end

  assign hit   = valid[idx] && (tags[idx] == tag);
  assign rdata = data[idx];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-through cache controller: hit detection,
// read-miss refill and write-through to the backing memory.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int LINES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MWR,
  input  logic              MOE,
  input  logic [ADDR_W-1:0] Adr,
  input  logic [WORD_W-1:0] MWD,
  output logic [WORD_W-1:0] CRD,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [WORD_W-1:0] mem_wd,
  input  logic [WORD_W-1:0] mem_rd,
  input  logic              mem_ack
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;

  state_t            state, next;
  addr_split_t       sp;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic [WORD_W-1:0] rdata;
  logic              we;
  logic [WORD_W-1:0] wdata;
  logic              launch;
  logic              finish;
  logic              unused_bits;

  assign sp  = split_addr(Adr, IDX_W);
  assign idx = sp.idx[IDX_W-1:0];
  assign tag = sp.tag[TAG_W-1:0];
  assign unused_bits = ^{sp.tag[ADDR_W-1:TAG_W],
                         sp.idx[ADDR_W-1:IDX_W]};

  cache_line_store #(
    .LINES(LINES),
    .IDX_W(IDX_W),
    .TAG_W(TAG_W)
  ) u_store (
    .clk  (clk),
    .rst  (rst),
    .idx  (idx),
    .tag  (tag),
    .we   (we),
    .wdata(wdata),
    .hit  (hit),
    .rdata(rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next  = state;
    we    = 1'b0;
    wdata = MWD;
    unique case (state)
      IDLE: begin
        if (MWR) begin
          next = WRITE;
          we   = hit;
        end else if (MOE) begin
          next = hit ? DONE : FILL;
        end
      end
      FILL: begin
        if (mem_req && mem_ack) begin
          next  = DONE;
          we    = 1'b1;
          wdata = mem_rd;
        end
      end
      WRITE: begin
        if (mem_req && mem_ack) next = DONE;
      end
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  assign launch = (state == IDLE) &&
                  (next == FILL || next == WRITE);
  assign finish = mem_req && mem_ack &&
                  (state == FILL || state == WRITE);
  assign done   = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      mem_adr <= '0;
      mem_wd  <= '0;
    end else if (launch) begin
      mem_req <= 1'b1;
      mem_we  <= MWR;
      mem_adr <= {Adr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
      mem_wd  <= MWR ? MWD : '0;
    end else if (finish) begin
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      mem_adr <= '0;
      mem_wd  <= '0;
    end
  end

  // Read data only changes on a read hit or a completed fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      CRD <= '0;
    end else if (state == IDLE && !MWR && MOE && hit) begin
      CRD <= rdata;
    end else if (state == FILL && finish) begin
      CRD <= mem_rd;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed self-checking bench for cache_ctrl.
// Inputs change 1ns after a rising edge; outputs are checked there too.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        MWR, MOE;
  logic [31:0] Adr, MWD;
  logic [31:0] CRD;
  logic        done;
  logic        mem_req, mem_we;
  logic [31:0] mem_adr, mem_wd, mem_rd;
  logic        mem_ack;

  int total = 0;
  int bad   = 0;

  cache_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .MWR    (MWR),
    .MOE    (MOE),
    .Adr    (Adr),
    .MWD    (MWD),
    .CRD    (CRD),
    .done   (done),
    .mem_req(mem_req),
    .mem_we (mem_we),
    .mem_adr(mem_adr),
    .mem_wd (mem_wd),
    .mem_rd (mem_rd),
    .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string t, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", t, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_miss(input string t, input logic [31:0] a,
                         input logic [31:0] fill);
    MOE = 1'b1; Adr = a;
    step();
    chk({t, ".req"}, {31'd0, mem_req}, 32'd1);
    chk({t, ".we"}, {31'd0, mem_we}, 32'd0);
    chk({t, ".adr"}, mem_adr, {a[31:2], 2'b00});
    chk({t, ".nodone"}, {31'd0, done}, 32'd0);
    step();
    mem_ack = 1'b1; mem_rd = fill;
    step();
    mem_ack = 1'b0; mem_rd = '0;
    chk({t, ".done"}, {31'd0, done}, 32'd1);
    chk({t, ".crd"}, CRD, fill);
    chk({t, ".reqdrop"}, {31'd0, mem_req}, 32'd0);
    MOE = 1'b0;
    step();
    chk({t, ".done0"}, {31'd0, done}, 32'd0);
  endtask

  task automatic rd_hit(input string t, input logic [31:0] a,
                        input logic [31:0] exp);
    MOE = 1'b1; Adr = a;
    step();
    chk({t, ".done"}, {31'd0, done}, 32'd1);
    chk({t, ".noreq"}, {31'd0, mem_req}, 32'd0);
    chk({t, ".crd"}, CRD, exp);
    MOE = 1'b0;
    step();
    chk({t, ".done0"}, {31'd0, done}, 32'd0);
  endtask

  task automatic wr(input string t, input logic [31:0] a,
                    input logic [31:0] d, input logic both,
                    input logic [31:0] crd_exp);
    MWR = 1'b1; MOE = both; Adr = a; MWD = d;
    step();
    chk({t, ".req"}, {31'd0, mem_req}, 32'd1);
    chk({t, ".we"}, {31'd0, mem_we}, 32'd1);
    chk({t, ".adr"}, mem_adr, {a[31:2], 2'b00});
    chk({t, ".wd"}, mem_wd, d);
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk({t, ".done"}, {31'd0, done}, 32'd1);
    chk({t, ".reqdrop"}, {31'd0, mem_req}, 32'd0);
    chk({t, ".crd"}, CRD, crd_exp);
    if (both) begin
      step();
      chk({t, ".held.noreq"}, {31'd0, mem_req}, 32'd0);
      chk({t, ".held.done0"}, {31'd0, done}, 32'd0);
      MWR = 1'b0; MOE = 1'b0;
      step();
      chk({t, ".held.idle"}, {31'd0, mem_req}, 32'd0);
    end else begin
      MWR = 1'b0; MOE = 1'b0;
      step();
      chk({t, ".done0"}, {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; MWR = 1'b0; MOE = 1'b0;
    Adr = '0; MWD = '0; mem_rd = '0; mem_ack = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst.crd", CRD, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.req", {31'd0, mem_req}, 32'd0);
    chk("rst.we", {31'd0, mem_we}, 32'd0);
    chk("rst.adr", mem_adr, 32'd0);
    chk("rst.wd", mem_wd, 32'd0);

    // First read misses; reset lands mid-fill, then a late ack.
    MOE = 1'b1; Adr = 32'd120;
    step();
    chk("miss0.req", {31'd0, mem_req}, 32'd1);
    chk("miss0.we", {31'd0, mem_we}, 32'd0);
    chk("miss0.adr", mem_adr, 32'd120);
    rst = 1'b1;
    step();
    rst = 1'b0; MOE = 1'b0;
    chk("rstfill.req", {31'd0, mem_req}, 32'd0);
    chk("rstfill.done", {31'd0, done}, 32'd0);
    mem_ack = 1'b1; mem_rd = 32'hBAD;
    step();
    mem_ack = 1'b0; mem_rd = '0;
    chk("lateack.done", {31'd0, done}, 32'd0);
    chk("lateack.crd", CRD, 32'd0);
    step();
    chk("lateack.done2", {31'd0, done}, 32'd0);

    wr("wr120", 32'd120, 32'd1, 1'b0, 32'd0);
    wr("wr110", 32'd110, 32'd2, 1'b0, 32'd0);
    rd_miss("rd120a", 32'd120, 32'd1);
    rd_hit("hit120", 32'd120, 32'd1);
    wr("wr120dead", 32'd120, 32'hDEAD, 1'b0, 32'd1);
    rd_hit("hit120dead", 32'd120, 32'hDEAD);
    rd_miss("rd184", 32'd184, 32'h55);
    rd_miss("rd120evict", 32'd120, 32'h77);
    rd_hit("hit120b", 32'd120, 32'h77);
    wr("both64", 32'd64, 32'h1234, 1'b1, 32'h77);
    rd_hit("hit120c", 32'd120, 32'h77);

    // Reset during a fill invalidates everything.
    MOE = 1'b1; Adr = 32'd184;
    step();
    chk("miss184b.req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; MOE = 1'b0;
    chk("rstfill2.req", {31'd0, mem_req}, 32'd0);
    chk("rstfill2.done", {31'd0, done}, 32'd0);
    mem_ack = 1'b1; mem_rd = 32'h99;
    step();
    mem_ack = 1'b0; mem_rd = '0;
    chk("lateack2.done", {31'd0, done}, 32'd0);
    chk("lateack2.req", {31'd0, mem_req}, 32'd0);
    rd_miss("rd120post", 32'd120, 32'h42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
